vip_feeder: RTL and testbench
=============================

Name: vip_feeder

Overview:
- Transmit-side driver for the floating-point dot-product engine.
- Buffers VEC_LEN operand pairs from a host load port.
- Sends the pairs to the engine as one contiguous in_valid burst, then waits for the engine's out_valid/out with a timeout.
- Returns the result, or a timeout indication, to the host as a one-cycle response.
- Performs no arithmetic; data movement and sequencing only.

Parameters:
FLOAT_LEN, 32, width of one IEEE-754 single-precision operand/result
VEC_LEN, 3, number of operand pairs per transaction (>=1)
TIMEOUT, 15, max WAIT cycles allowed for the engine response (>=1)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
load_valid  input  1  host offers load_a/load_b this cycle
load_a  input  FLOAT_LEN  vector_1 element
load_b  input  FLOAT_LEN  vector_2 element
load_ready  output  1  feeder accepts a pair this cycle
dp_in_valid  output  1  engine input valid
dp_vector_1  output  FLOAT_LEN  engine operand a
dp_vector_2  output  FLOAT_LEN  engine operand b
dp_out_valid  input  1  engine result valid
dp_out  input  FLOAT_LEN  engine result
res_valid  output  1  one-cycle response pulse
res  output  FLOAT_LEN  captured result
res_timeout  output  1  response is a timeout

Behaviour:
- States: LOAD, SEND, WAIT. Reset state is LOAD.
- Reset values:
  - all outputs 0, except load_ready=1 (combinational: state==LOAD);
  - wr_ptr/rd_ptr/timeout counter 0.
  - Buffer contents need not be reset.
- LOAD:
  - A pair is accepted on an edge where load_valid&&load_ready. It is written to buf[wr_ptr] and wr_ptr increments.
  - Gaps (load_valid low) are allowed.
  - The accept at wr_ptr==VEC_LEN-1 wraps wr_ptr to 0 and moves to SEND on the same edge.
- SEND:
  - dp_in_valid/dp_vector_1/dp_vector_2 are registered outputs.
  - If the last pair is accepted at edge E, dp_in_valid is high for exactly VEC_LEN consecutive cycles starting at edge E+1. Elements are presented in load order, index 0 first.
  - While dp_in_valid is low, dp_vector_1 and dp_vector_2 are 0.
  - The edge that drops dp_in_valid also enters WAIT and clears the timeout counter.
- WAIT:
  - Each cycle in WAIT is counted k=1,2,...
  - If dp_out_valid is high in WAIT cycle k<=TIMEOUT:
    - at that edge res<=dp_out, res_timeout<=0, res_valid<=1;
    - state goes to LOAD.
  - If k=TIMEOUT passes without dp_out_valid:
    - at that edge res<=0, res_timeout<=1, res_valid<=1;
    - state goes to LOAD.
  - dp_out_valid on cycle k=TIMEOUT is a success; the response has priority over the timeout.
- Response outputs:
  - res_valid is high for exactly one cycle.
  - res and res_timeout are 0 whenever res_valid is 0.
  - load_ready is already 1 in the res_valid cycle, so back-to-back transactions are allowed.
- Ignored inputs:
  - load_valid outside LOAD is ignored; load_ready=0 there.
  - dp_out_valid outside WAIT (including during SEND) is ignored.
  - A second dp_out_valid after the response is ignored.
- Reset mid-operation: reset asserted in any state immediately clears all outputs and returns to LOAD with empty pointers. Partially loaded pairs are discarded.

Test Plan:
- Load (0x3F800000,0x40000000), (0x40400000,0x40800000), (0x40A00000,0x40C00000) back-to-back:
  - dp_in_valid is high 3 cycles starting the cycle after the third accept, pairs in order;
  - the model engine returns 0x42300000 -> single res_valid pulse, res=0x42300000, res_timeout=0.
- Same pairs with 2 idle cycles between loads -> identical contiguous 3-cycle burst and identical response.
- Engine never asserts dp_out_valid -> after 15 WAIT cycles: res_valid=1, res=0, res_timeout=1; load_ready=1 that cycle.
- Engine asserts dp_out_valid (0x41200000) exactly on WAIT cycle 15 -> success, res=0x41200000, res_timeout=0.
- dp_out_valid pulsed during SEND plus load_valid held high during SEND/WAIT -> both ignored; the next transaction uses only newly loaded pairs.
- rst_n low during the 2nd SEND cycle -> dp_in_valid and dp_vector_1/dp_vector_2 go 0 immediately; after release load_ready=1 and a fresh 3-pair load produces a correct burst.

Source files
------------

// File: rtl/vip_feeder_if.sv
// rtl/vip_feeder_if.sv - host load, engine and response signal bundle for vip_feeder
//
// Purpose: groups the host load port, the dot-product engine port and the
// response port of vip_feeder into a single interface.
// Ports (signals):
//   load_valid/load_a/load_b  host -> feeder operand pair offer
//   load_ready                feeder -> host, pair accepted this cycle
//   dp_in_valid/dp_vector_1/2 feeder -> engine operand stream
//   dp_out_valid/dp_out       engine -> feeder result
//   res_valid/res/res_timeout feeder -> host one-cycle response
// Modports: slave = the feeder, master = the host/engine side.

interface vip_feeder_if #(
  parameter int FLOAT_LEN = 32
);
  logic                 load_valid;
  logic [FLOAT_LEN-1:0] load_a;
  logic [FLOAT_LEN-1:0] load_b;
  logic                 load_ready;
  logic                 dp_in_valid;
  logic [FLOAT_LEN-1:0] dp_vector_1;
  logic [FLOAT_LEN-1:0] dp_vector_2;
  logic                 dp_out_valid;
  logic [FLOAT_LEN-1:0] dp_out;
  logic                 res_valid;
  logic [FLOAT_LEN-1:0] res;
  logic                 res_timeout;

  modport slave (
    input  load_valid, load_a, load_b, dp_out_valid, dp_out,
    output load_ready, dp_in_valid, dp_vector_1, dp_vector_2,
           res_valid, res, res_timeout
  );

  modport master (
    output load_valid, load_a, load_b, dp_out_valid, dp_out,
    input  load_ready, dp_in_valid, dp_vector_1, dp_vector_2,
           res_valid, res, res_timeout
  );
endinterface

// File: rtl/vip_feeder.sv
// rtl/vip_feeder.sv - operand buffer and sequencer for the dot-product engine
//
// Purpose: collects VEC_LEN operand pairs from the host, streams them to the
// engine as one contiguous dp_in_valid burst, then waits up to TIMEOUT cycles
// for the engine result and returns it (or a timeout) as a one-cycle pulse.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    vip_feeder_if.slave (load, engine and response signals)

module vip_feeder #(
  parameter int FLOAT_LEN = 32,
  parameter int VEC_LEN   = 3,
  parameter int TIMEOUT   = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  vip_feeder_if.slave    bus
);

  localparam int PTR_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(VEC_LEN - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 dp_in_valid_q, dp_in_valid_d;
  logic [FLOAT_LEN-1:0] dp_v1_q, dp_v1_d;
  logic [FLOAT_LEN-1:0] dp_v2_q, dp_v2_d;
  logic                 res_valid_q, res_valid_d;
  logic [FLOAT_LEN-1:0] res_q, res_d;
  logic                 res_timeout_q, res_timeout_d;

  logic [FLOAT_LEN-1:0] mem_a [VEC_LEN];
  logic [FLOAT_LEN-1:0] mem_b [VEC_LEN];

  logic load_ready;
  logic load_fire;

  assign load_ready = (state_q == ST_LOAD);
  assign load_fire  = bus.load_valid && load_ready;

  // Operand storage carries no reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      mem_a[wr_ptr_q] <= bus.load_a;
      mem_b[wr_ptr_q] <= bus.load_b;
    end
  end

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    tmo_d         = tmo_q;
    dp_in_valid_d = 1'b0;
    dp_v1_d       = '0;
    dp_v2_d       = '0;
    res_valid_d   = 1'b0;
    res_d         = '0;
    res_timeout_d = 1'b0;

    case (state_q)
      ST_LOAD: begin
        if (load_fire) begin
          if (wr_ptr_q == LAST_IDX) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            state_d  = ST_SEND;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end

      ST_SEND: begin
        // rd_ptr back at 0 with the burst already running means every
        // element has been presented; this edge closes the burst.
        if (dp_in_valid_q && (rd_ptr_q == '0)) begin
          state_d = ST_WAIT;
          tmo_d   = '0;
        end else begin
          dp_in_valid_d = 1'b1;
          dp_v1_d       = mem_a[rd_ptr_q];
          dp_v2_d       = mem_b[rd_ptr_q];
          rd_ptr_d      = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
        end
      end

      ST_WAIT: begin
        // tmo_q holds the number of WAIT cycles already elapsed, so the
        // current edge is WAIT cycle tmo_q+1. A result wins over the timeout.
        if (bus.dp_out_valid) begin
          res_valid_d = 1'b1;
          res_d       = bus.dp_out;
          state_d     = ST_LOAD;
        end else if (tmo_q == TMO_LAST) begin
          res_valid_d   = 1'b1;
          res_timeout_d = 1'b1;
          state_d       = ST_LOAD;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      default: begin
        state_d  = ST_LOAD;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        tmo_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_LOAD;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      tmo_q         <= '0;
      dp_in_valid_q <= 1'b0;
      dp_v1_q       <= '0;
      dp_v2_q       <= '0;
      res_valid_q   <= 1'b0;
      res_q         <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      tmo_q         <= tmo_d;
      dp_in_valid_q <= dp_in_valid_d;
      dp_v1_q       <= dp_v1_d;
      dp_v2_q       <= dp_v2_d;
      res_valid_q   <= res_valid_d;
      res_q         <= res_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  assign bus.load_ready  = load_ready;
  assign bus.dp_in_valid = dp_in_valid_q;
  assign bus.dp_vector_1 = dp_v1_q;
  assign bus.dp_vector_2 = dp_v2_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res         = res_q;
  assign bus.res_timeout = res_timeout_q;

endmodule

// File: tb/tb_vip_feeder.sv
// tb/tb_vip_feeder.sv - directed self-checking bench for vip_feeder

module tb_vip_feeder;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  logic [31:0] va [3];
  logic [31:0] vb [3];

  vip_feeder_if #(.FLOAT_LEN(32)) bus ();

  vip_feeder #(
    .FLOAT_LEN(32),
    .VEC_LEN  (3),
    .TIMEOUT  (15)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_x();
    va[0] = 32'h3F800000; vb[0] = 32'h40000000;
    va[1] = 32'h40400000; vb[1] = 32'h40800000;
    va[2] = 32'h40A00000; vb[2] = 32'h40C00000;
  endtask

  task automatic set_y();
    va[0] = 32'h41000000; vb[0] = 32'h41300000;
    va[1] = 32'h41100000; vb[1] = 32'h41400000;
    va[2] = 32'h41200000; vb[2] = 32'h41500000;
  endtask

  // Offers va/vb in order with gap idle cycles between pairs; returns just
  // after the edge that accepted the third pair, with load_valid low.
  task automatic load_three(input int gap);
    for (int i = 0; i < 3; i++) begin
      bus.load_valid = 1'b1;
      bus.load_a     = va[i];
      bus.load_b     = vb[i];
      step();
      bus.load_valid = 1'b0;
      bus.load_a     = '0;
      bus.load_b     = '0;
      if (i < 2) repeat (gap) step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    n_cmp++;
    if (bus.load_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_load_ready: got %b want 1", bus.load_ready);
    end
    n_cmp++;
    if ({bus.dp_in_valid, bus.dp_vector_1, bus.dp_vector_2, bus.res_valid, bus.res, bus.res_timeout} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got dpv=%b v1=%h v2=%h rv=%b res=%h to=%b want all 0",
        bus.dp_in_valid, bus.dp_vector_1, bus.dp_vector_2, bus.res_valid, bus.res, bus.res_timeout);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic(input int gap, input string tag);
    set_x();
    load_three(gap);
    n_cmp++;
    if (bus.load_ready !== 1'b0) begin
      n_err++; $display("FAIL %s_ready_in_send: got %b want 0", tag, bus.load_ready);
    end
    n_cmp++;
    if (bus.dp_in_valid !== 1'b0) begin
      n_err++; $display("FAIL %s_burst_early: got %b want 0", tag, bus.dp_in_valid);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ({bus.dp_in_valid, bus.dp_vector_1, bus.dp_vector_2} !== {1'b1, va[i], vb[i]}) begin
        n_err++; $display("FAIL %s_burst[%0d]: got v=%b a=%h b=%h want v=1 a=%h b=%h",
          tag, i, bus.dp_in_valid, bus.dp_vector_1, bus.dp_vector_2, va[i], vb[i]);
      end
    end
    step();
    n_cmp++;
    if ({bus.dp_in_valid, bus.dp_vector_1, bus.dp_vector_2} !== '0) begin
      n_err++; $display("FAIL %s_burst_end: got v=%b a=%h b=%h want 0 0 0",
        tag, bus.dp_in_valid, bus.dp_vector_1, bus.dp_vector_2);
    end
    bus.dp_out_valid = 1'b1;
    bus.dp_out       = 32'h42300000;
    step();
    bus.dp_out_valid = 1'b0;
    bus.dp_out       = '0;
    n_cmp++;
    if ({bus.res_valid, bus.res, bus.res_timeout, bus.load_ready} !== {1'b1, 32'h42300000, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL %s_response: got rv=%b res=%h to=%b rdy=%b want 1 42300000 0 1",
        tag, bus.res_valid, bus.res, bus.res_timeout, bus.load_ready);
    end
    step();
    n_cmp++;
    if ({bus.res_valid, bus.res, bus.res_timeout} !== '0) begin
      n_err++; $display("FAIL %s_response_pulse: got rv=%b res=%h to=%b want 0 0 0",
        tag, bus.res_valid, bus.res, bus.res_timeout);
    end
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    set_x();
    load_three(0);
    repeat (4) step();
    for (int k = 1; k <= 40; k++) begin
      step();
      if (bus.res_valid === 1'b1) begin
        n = k;
        break;
      end
    end
    n_cmp++;
    if (n != 15) begin
      n_err++; $display("FAIL timeout_cycles: got %0d want 15 (0 = no response in 40)", n);
    end
    n_cmp++;
    if ({bus.res_valid, bus.res, bus.res_timeout, bus.load_ready} !== {1'b1, 32'h0, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL timeout_response: got rv=%b res=%h to=%b rdy=%b want 1 0 1 1",
        bus.res_valid, bus.res, bus.res_timeout, bus.load_ready);
    end
    step();
    n_cmp++;
    if ({bus.res_valid, bus.res_timeout} !== 2'b00) begin
      n_err++; $display("FAIL timeout_pulse: got rv=%b to=%b want 0 0", bus.res_valid, bus.res_timeout);
    end
  endtask

  task automatic test_last_cycle_success();
    logic early;
    early = 1'b0;
    set_x();
    load_three(0);
    repeat (4) step();
    for (int k = 1; k <= 14; k++) begin
      step();
      if (bus.res_valid !== 1'b0) early = 1'b1;
    end
    n_cmp++;
    if (early !== 1'b0) begin
      n_err++; $display("FAIL k15_early_response: got %b want 0", early);
    end
    bus.dp_out_valid = 1'b1;
    bus.dp_out       = 32'h41200000;
    step();
    bus.dp_out_valid = 1'b0;
    bus.dp_out       = '0;
    n_cmp++;
    if ({bus.res_valid, bus.res, bus.res_timeout} !== {1'b1, 32'h41200000, 1'b0}) begin
      n_err++; $display("FAIL k15_response: got rv=%b res=%h to=%b want 1 41200000 0",
        bus.res_valid, bus.res, bus.res_timeout);
    end
    step();
  endtask

  task automatic test_ignored_inputs();
    set_x();
    load_three(0);
    bus.load_valid   = 1'b1;
    bus.load_a       = 32'hDEADBEEF;
    bus.load_b       = 32'hCAFEF00D;
    bus.dp_out_valid = 1'b1;
    bus.dp_out       = 32'h11111111;
    for (int i = 0; i < 3; i++) begin
      step();
      bus.dp_out_valid = (i == 0);
      n_cmp++;
      if ({bus.dp_in_valid, bus.dp_vector_1, bus.dp_vector_2, bus.res_valid} !== {1'b1, va[i], vb[i], 1'b0}) begin
        n_err++; $display("FAIL ign_burst[%0d]: got v=%b a=%h b=%h rv=%b want v=1 a=%h b=%h rv=0",
          i, bus.dp_in_valid, bus.dp_vector_1, bus.dp_vector_2, bus.res_valid, va[i], vb[i]);
      end
    end
    bus.dp_out_valid = 1'b0;
    repeat (3) step();
    n_cmp++;
    if ({bus.res_valid, bus.load_ready} !== 2'b00) begin
      n_err++; $display("FAIL ign_wait_quiet: got rv=%b rdy=%b want 0 0", bus.res_valid, bus.load_ready);
    end
    bus.load_valid   = 1'b0;
    bus.load_a       = '0;
    bus.load_b       = '0;
    bus.dp_out_valid = 1'b1;
    bus.dp_out       = 32'h22222222;
    step();
    n_cmp++;
    if ({bus.res_valid, bus.res, bus.res_timeout} !== {1'b1, 32'h22222222, 1'b0}) begin
      n_err++; $display("FAIL ign_response: got rv=%b res=%h to=%b want 1 22222222 0",
        bus.res_valid, bus.res, bus.res_timeout);
    end
    step();
    bus.dp_out_valid = 1'b0;
    bus.dp_out       = '0;
    n_cmp++;
    if ({bus.res_valid, bus.res} !== 33'h0) begin
      n_err++; $display("FAIL ign_second_out_valid: got rv=%b res=%h want 0 0", bus.res_valid, bus.res);
    end
    set_y();
    load_three(0);
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ({bus.dp_in_valid, bus.dp_vector_1, bus.dp_vector_2} !== {1'b1, va[i], vb[i]}) begin
        n_err++; $display("FAIL ign_next_burst[%0d]: got v=%b a=%h b=%h want v=1 a=%h b=%h",
          i, bus.dp_in_valid, bus.dp_vector_1, bus.dp_vector_2, va[i], vb[i]);
      end
    end
    step();
    bus.dp_out_valid = 1'b1;
    bus.dp_out       = 32'h33333333;
    step();
    bus.dp_out_valid = 1'b0;
    bus.dp_out       = '0;
    step();
  endtask

  task automatic test_reset_mid_send();
    set_x();
    load_three(0);
    step();
    step();
    n_cmp++;
    if ({bus.dp_in_valid, bus.dp_vector_1} !== {1'b1, va[1]}) begin
      n_err++; $display("FAIL rst_pre_send2: got v=%b a=%h want 1 %h", bus.dp_in_valid, bus.dp_vector_1, va[1]);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.dp_in_valid, bus.dp_vector_1, bus.dp_vector_2, bus.load_ready} !== {1'b0, 32'h0, 32'h0, 1'b1}) begin
      n_err++; $display("FAIL rst_async_clear: got v=%b a=%h b=%h rdy=%b want 0 0 0 1",
        bus.dp_in_valid, bus.dp_vector_1, bus.dp_vector_2, bus.load_ready);
    end
    repeat (2) step();
    rst_n = 1'b1;
    step();
    n_cmp++;
    if ({bus.load_ready, bus.dp_in_valid, bus.res_valid} !== 3'b100) begin
      n_err++; $display("FAIL rst_after_release: got rdy=%b v=%b rv=%b want 1 0 0",
        bus.load_ready, bus.dp_in_valid, bus.res_valid);
    end
    set_y();
    load_three(1);
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ({bus.dp_in_valid, bus.dp_vector_1, bus.dp_vector_2} !== {1'b1, va[i], vb[i]}) begin
        n_err++; $display("FAIL rst_fresh_burst[%0d]: got v=%b a=%h b=%h want v=1 a=%h b=%h",
          i, bus.dp_in_valid, bus.dp_vector_1, bus.dp_vector_2, va[i], vb[i]);
      end
    end
    step();
    n_cmp++;
    if (bus.dp_in_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_fresh_burst_end: got %b want 0", bus.dp_in_valid);
    end
  endtask

  initial begin
    n_cmp            = 0;
    n_err            = 0;
    rst_n            = 1'b0;
    bus.load_valid   = 1'b0;
    bus.load_a       = '0;
    bus.load_b       = '0;
    bus.dp_out_valid = 1'b0;
    bus.dp_out       = '0;
    test_reset();
    test_basic(0, "b2b");
    test_basic(2, "gap2");
    test_timeout();
    test_last_cycle_success();
    test_ignored_inputs();
    test_reset_mid_send();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
